// File: rtl/uart_rx_perif_if.sv
// CPU bus bundle for the UART receiver: register select, strobes and data in both directions.
interface uart_rx_perif_if;
    logic [1:0] AB;
    logic       WE;
    logic       CS;
    logic [7:0] DI;
    logic [7:0] DO;

    modport master (output AB, output WE, output CS, output DI, input DO);
    modport slave  (input AB, input WE, input CS, input DI, output DO);
endinterface

// File: rtl/uart_rx_perif.sv
// 8N1 UART receiver with a small receive FIFO, status/control registers and a level interrupt.
module uart_rx_perif #(
    parameter int unsigned CLKS_PER_BIT = 234,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_rx_perif_if.slave bus,
    input  logic           rx_pin,
    output logic           irq
);
    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam logic [CntW-1:0] HalfTc = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] FullTc = CntW'(CLKS_PER_BIT - 1);
    localparam logic [PtrW:0]   DepthV = (PtrW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            rx_meta_q, rx_s_q;
    logic            stop_sample, stop_good;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]   count_q;
    logic            empty, full, busy, push, pop;
    logic            rd0, rd0_q, wr;
    logic            overrun_q, frame_err_q, irq_en_q, irq_q;
    logic            ov_set, fe_set;
    logic [7:0]      rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
        end else begin
            rx_meta_q <= rx_pin;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        stop_sample = 1'b0;
        stop_good   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!rx_s_q) begin
                    cnt_d   = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (cnt_q == HalfTc) begin
                    cnt_d = '0;
                    bit_d = '0;
                    // A line that is high again at mid start bit was a glitch.
                    state_d = rx_s_q ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (cnt_q == FullTc) begin
                    cnt_d          = '0;
                    shift_d[bit_q] = rx_s_q;
                    bit_d          = bit_q + 1'b1;
                    if (bit_q == 3'd7) state_d = StStop;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (cnt_q == FullTc) begin
                    cnt_d       = '0;
                    stop_sample = 1'b1;
                    stop_good   = rx_s_q;
                    state_d     = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy  = (state_q != StIdle);
    assign empty = (count_q == '0);
    assign full  = (count_q == DepthV);
    assign rd0   = bus.CS && !bus.WE && (bus.AB == 2'd0);
    assign wr    = bus.CS && bus.WE;
    // Pop only on the first edge of a read access so a long CS pops once.
    assign pop    = rd0 && !rd0_q && !empty;
    assign push   = stop_good && (!full || pop);
    assign ov_set = stop_good && full && !pop;
    assign fe_set = stop_sample && !rx_s_q;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= shift_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd0_q       <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            irq_en_q    <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            rd0_q <= rd0;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
            if (ov_set)                                     overrun_q <= 1'b1;
            else if (wr && bus.AB == 2'd1 && bus.DI[1])     overrun_q <= 1'b0;
            if (fe_set)                                     frame_err_q <= 1'b1;
            else if (wr && bus.AB == 2'd1 && bus.DI[2])     frame_err_q <= 1'b0;
            if (wr && bus.AB == 2'd2) irq_en_q <= bus.DI[7];
            irq_q <= irq_en_q && (!empty || overrun_q || frame_err_q);
        end
    end

    always_comb begin
        rdata = 8'h00;
        unique case (bus.AB)
            2'd0:    rdata = empty ? 8'h00 : mem[rd_ptr_q];
            2'd1:    rdata = {3'b000, full, busy, frame_err_q, overrun_q, !empty};
            2'd2:    rdata = {irq_en_q, 2'b00, 5'(count_q)};
            default: rdata = 8'h00;
        endcase
    end

    assign bus.DO = (bus.CS && !bus.WE) ? rdata : 8'bz;
    assign irq    = irq_q;
endmodule

// File: doc/uart_rx_perif.md
Name: uart_rx_perif

Overview:
- Memory-mapped UART receiver for the 6502 system bus. It is the receive-side counterpart of the bus UART transmitter.
- Samples an asynchronous 8N1 serial line at CLKS_PER_BIT clocks per bit and pushes good bytes into a small FIFO.
- Exposes data, status and control registers on the CPU bus, plus a level interrupt.
- The CPU reads bytes by polling or on irq.

Parameters:
- CLKS_PER_BIT, 234, clk cycles per bit (27 MHz / 115200); must be >= 4.
- FIFO_DEPTH, 4, receive FIFO entries; power of two, 2..16.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- AB  in  2  register select.
- WE  in  1  1 = write cycle, 0 = read cycle.
- CS  in  1  peripheral select.
- DI  in  8  write data.
- DO  out  8  read data; 8'bz unless CS && ~WE.
- rx_pin  in  1  serial input, idle high, asynchronous.
- irq  out  1  level interrupt.

Behaviour:
- Reset values:
  - 2-FF synchronizer = 1, state = IDLE, counters = 0.
  - FIFO empty, overrun = 0, frame_err = 0, irq_en = 0.
  - irq = 0; DO = z.
- Reset asserted mid-frame aborts the frame and flushes the FIFO. No byte is pushed.
- rx_s is the synchronized rx_pin (2 flops).
- IDLE: when rx_s == 0, load cnt = 0 and go to START.
- START: count to CLKS_PER_BIT/2 - 1 (integer division). At terminal count:
  - rx_s == 0: go to DATA with cnt = 0 and bit = 0.
  - rx_s == 1: glitch. Return to IDLE with no flag.
- DATA: at cnt == CLKS_PER_BIT - 1, sample rx_s into shift[bit], LSB first, and reset cnt. After bit 7, go to STOP.
- STOP: at cnt == CLKS_PER_BIT - 1, sample rx_s and go to IDLE in the same cycle.
  - Sample 1 and FIFO not full: push the byte.
  - Sample 1 and FIFO full: byte is dropped; overrun <= 1.
  - Sample 0: byte is dropped; frame_err <= 1.
- busy = (state != IDLE).
- A pushed byte is visible (rx_valid = 1) on the cycle after the stop-bit sample.
- Register map:
  - AB=0, read: FIFO head, or 8'h00 when empty. Pop occurs on the first clk edge of a read access, i.e. the rd0 rising edge, where rd0 = CS && ~WE && AB==0. A multi-cycle CS pops once; a pop on empty does nothing. AB=0 writes are ignored.
  - AB=1, read: {3'b0, full, busy, frame_err, overrun, rx_valid}.
  - AB=1, write: DI[1]=1 clears overrun and DI[2]=1 clears frame_err (write-1-to-clear).
  - AB=2, read: {irq_en, 2'b0, count[4:0]}. AB=2 write: irq_en <= DI[7].
  - AB=3: reads 8'h00; writes ignored.
- Writes take effect on the posedge where CS && WE is true.
- Simultaneous events:
  - Push and pop in the same cycle with FIFO full: pop first, push accepted, no overrun.
  - Flag set and W1C clear in the same cycle: the set wins.
- FIFO pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH.
- irq = irq_en && (rx_valid || overrun || frame_err); it is registered, 1 cycle after its condition.

Test Plan:
- CLKS_PER_BIT=8, send 0xA5 as 8N1, then read AB=1 and AB=0 -> status 0x01 one cycle after the stop sample; AB=0 returns 0xA5; then status 0x00 and count 0.
- Send 0x11, 0x22, 0x33, 0x44, 0x55 with no reads (FIFO_DEPTH=4) -> count 4, full=1, overrun=1; reads return 0x11..0x44; write AB=1 DI=0x02 clears overrun.
- Send a frame with stop bit = 0 -> frame_err=1, count 0; write AB=1 DI=0x04 clears it.
- Drive a low pulse of 3 clks on rx_pin -> returns to IDLE, busy falls, no flags, count 0.
- Set irq_en via AB=2 DI=0x80, then receive 0x3C -> irq=1; hold a read of AB=0 for 3 cycles -> single pop, irq=0, count 0.
- Assert rst_n=0 at DATA bit 4 with 2 bytes queued -> all outputs return to reset values, count 0; the next full frame 0x7E is received correctly.
